// File: rtl/comparador_temp_histeresis_if.sv
// Sample-in / classification-out bundle between the sensor scaling stage
// and the temperature classifier.
interface comparador_temp_histeresis_if #(
    parameter int ANCHO     = 11,
    parameter int ANCHO_CNT = 8
);
    logic                    temp_valida;
    logic signed [ANCHO-1:0] temp_entrada;
    logic [1:0]              estado;
    logic                    fuera_rango;
    logic                    alarma;
    logic                    cambio;
    logic [ANCHO_CNT-1:0]    num_alarmas;

    modport master (
        output temp_valida, temp_entrada,
        input  estado, fuera_rango, alarma, cambio, num_alarmas
    );

    modport slave (
        input  temp_valida, temp_entrada,
        output estado, fuera_rango, alarma, cambio, num_alarmas
    );
endinterface

// File: rtl/comparador_temp_histeresis.sv
// Debounced temperature classifier with hysteresis and a saturating alarm counter.
// state    | meaning
// NORMAL   | temperature inside [TEMP_BAJO, TEMP_ALTO] (with return hysteresis)
// FRIO     | temperature confirmed below TEMP_BAJO
// CALIENTE | temperature confirmed above TEMP_ALTO
module comparador_temp_histeresis #(
    parameter int ANCHO      = 11,
    parameter int TEMP_BAJO  = 180,
    parameter int TEMP_ALTO  = 259,
    parameter int HIST       = 5,
    parameter int N_MUESTRAS = 4,
    parameter int ANCHO_CNT  = 8
) (
    input logic clk,
    input logic rst,
    comparador_temp_histeresis_if.slave bus
);
    localparam int CW = (N_MUESTRAS < 1) ? 1 : $clog2(N_MUESTRAS + 1);

    // Thresholds widened by one bit so the +/-HIST offsets cannot wrap.
    localparam logic signed [ANCHO:0] BAJO      = (ANCHO+1)'(TEMP_BAJO);
    localparam logic signed [ANCHO:0] ALTO      = (ANCHO+1)'(TEMP_ALTO);
    localparam logic signed [ANCHO:0] BAJO_HIST = (ANCHO+1)'(TEMP_BAJO + HIST);
    localparam logic signed [ANCHO:0] ALTO_HIST = (ANCHO+1)'(TEMP_ALTO - HIST);
    localparam logic [CW-1:0]         N_CW      = CW'(N_MUESTRAS);
    localparam logic [ANCHO_CNT-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        FRIO     = 2'b01,
        CALIENTE = 2'b10
    } estado_t;

    estado_t              estado_q, estado_d;
    estado_t              candidato_q, candidato_d;
    estado_t              obj;
    logic [CW-1:0]        cuenta_q, cuenta_d;
    logic [CW-1:0]        cuenta_inc;
    logic                 fuera_rango_q, fuera_rango_d;
    logic                 alarma_q, alarma_d;
    logic                 cambio_q, cambio_d;
    logic [ANCHO_CNT-1:0] num_alarmas_q, num_alarmas_d;
    logic signed [ANCHO:0] temp_ext;
    logic                 tomar;

    assign temp_ext   = {bus.temp_entrada[ANCHO-1], bus.temp_entrada};
    assign cuenta_inc = cuenta_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q      <= NORMAL;
            candidato_q   <= NORMAL;
            cuenta_q      <= '0;
            fuera_rango_q <= 1'b0;
            alarma_q      <= 1'b0;
            cambio_q      <= 1'b0;
            num_alarmas_q <= '0;
        end else begin
            estado_q      <= estado_d;
            candidato_q   <= candidato_d;
            cuenta_q      <= cuenta_d;
            fuera_rango_q <= fuera_rango_d;
            alarma_q      <= alarma_d;
            cambio_q      <= cambio_d;
            num_alarmas_q <= num_alarmas_d;
        end
    end

    always_comb begin
        obj = estado_q;
        unique case (estado_q)
            NORMAL: begin
                if (temp_ext < BAJO)      obj = FRIO;
                else if (temp_ext > ALTO) obj = CALIENTE;
                else                      obj = NORMAL;
            end
            FRIO: begin
                if (temp_ext > ALTO)            obj = CALIENTE;
                else if (temp_ext >= BAJO_HIST) obj = NORMAL;
                else                            obj = FRIO;
            end
            CALIENTE: begin
                if (temp_ext < BAJO)            obj = FRIO;
                else if (temp_ext <= ALTO_HIST) obj = NORMAL;
                else                            obj = CALIENTE;
            end
            default: obj = NORMAL;
        endcase
    end

    always_comb begin
        estado_d      = estado_q;
        candidato_d   = candidato_q;
        cuenta_d      = cuenta_q;
        alarma_d      = 1'b0;
        cambio_d      = 1'b0;
        num_alarmas_d = num_alarmas_q;
        tomar         = 1'b0;

        if (bus.temp_valida) begin
            if (obj == estado_q) begin
                cuenta_d = '0;
            end else if (obj == candidato_q) begin
                if (cuenta_inc == N_CW) tomar = 1'b1;
                else                    cuenta_d = cuenta_inc;
            end else begin
                candidato_d = obj;
                if (N_MUESTRAS == 1) tomar = 1'b1;
                else                 cuenta_d = CW'(1);
            end
        end

        if (tomar) begin
            estado_d = obj;
            cuenta_d = '0;
            cambio_d = 1'b1;
            // Any entry into an out-of-range class counts, including CALIENTE<->FRIO.
            if (obj != NORMAL) begin
                alarma_d = 1'b1;
                if (num_alarmas_q != CNT_MAX) num_alarmas_d = num_alarmas_q + 1'b1;
            end
        end

        fuera_rango_d = (estado_d != NORMAL);
    end

    assign bus.estado      = estado_q;
    assign bus.fuera_rango = fuera_rango_q;
    assign bus.alarma      = alarma_q;
    assign bus.cambio      = cambio_q;
    assign bus.num_alarmas = num_alarmas_q;
endmodule

// File: tb/tb_comparador_temp_histeresis.sv
// Directed bench for the temperature classifier, built with a 2-bit alarm counter
// so saturation is reachable.
module tb_comparador_temp_histeresis;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    comparador_temp_histeresis_if #(.ANCHO(11), .ANCHO_CNT(2)) bus ();

    comparador_temp_histeresis #(
        .ANCHO(11), .TEMP_BAJO(180), .TEMP_ALTO(259), .HIST(5),
        .N_MUESTRAS(4), .ANCHO_CNT(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Packs {estado, fuera_rango, alarma, cambio, num_alarmas} for one-shot compares.
    function automatic logic [6:0] obs();
        return {bus.estado, bus.fuera_rango, bus.alarma, bus.cambio, bus.num_alarmas};
    endfunction

    function automatic logic [6:0] exp_v(logic [1:0] e, logic a, logic c, logic [1:0] n);
        return {e, (e != 2'b00), a, c, n};
    endfunction

    task automatic send(input int v);
        @(negedge clk);
        bus.temp_valida  = 1'b1;
        bus.temp_entrada = 11'(v);
        @(negedge clk);
        bus.temp_valida  = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.temp_valida  = 1'b1;
        bus.temp_entrada = -11'sd1024;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs() !== exp_v(2'b00, 0, 0, 2'd0)) begin
            errors++;
            $display("FAIL reset_hold got=%b want=%b", obs(), exp_v(2'b00, 0, 0, 2'd0));
        end
        bus.temp_valida = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_in_range();
        for (int i = 0; i < 10; i++) begin
            send(220);
            checks++;
            if (obs() !== exp_v(2'b00, 0, 0, 2'd0)) begin
                errors++;
                $display("FAIL in_range[%0d] got=%b want=%b", i, obs(), exp_v(2'b00, 0, 0, 2'd0));
            end
        end
    endtask

    task automatic test_debounce();
        for (int i = 0; i < 3; i++) send(170);
        send(220);
        for (int i = 0; i < 3; i++) send(170);
        checks++;
        if (obs() !== exp_v(2'b00, 0, 0, 2'd0)) begin
            errors++;
            $display("FAIL debounce_early got=%b want=%b", obs(), exp_v(2'b00, 0, 0, 2'd0));
        end
        send(170);
        checks++;
        if (obs() !== exp_v(2'b01, 1, 1, 2'd1)) begin
            errors++;
            $display("FAIL debounce_enter got=%b want=%b", obs(), exp_v(2'b01, 1, 1, 2'd1));
        end
        idle();
        checks++;
        if (obs() !== exp_v(2'b01, 0, 0, 2'd1)) begin
            errors++;
            $display("FAIL debounce_pulse_end got=%b want=%b", obs(), exp_v(2'b01, 0, 0, 2'd1));
        end
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < 6; i++) send(182);
        checks++;
        if (obs() !== exp_v(2'b01, 0, 0, 2'd1)) begin
            errors++;
            $display("FAIL hyst_hold got=%b want=%b", obs(), exp_v(2'b01, 0, 0, 2'd1));
        end
        for (int i = 0; i < 4; i++) send(185);
        checks++;
        if (obs() !== exp_v(2'b00, 0, 1, 2'd1)) begin
            errors++;
            $display("FAIL hyst_exit got=%b want=%b", obs(), exp_v(2'b00, 0, 1, 2'd1));
        end
    endtask

    task automatic test_gapped();
        send(270); idle(); send(270); idle(); send(150);
        for (int i = 0; i < 3; i++) begin idle(); send(270); end
        checks++;
        if (obs() !== exp_v(2'b00, 0, 0, 2'd1)) begin
            errors++;
            $display("FAIL gapped_not_yet got=%b want=%b", obs(), exp_v(2'b00, 0, 0, 2'd1));
        end
        idle(); send(270);
        checks++;
        if (obs() !== exp_v(2'b10, 1, 1, 2'd2)) begin
            errors++;
            $display("FAIL gapped_enter got=%b want=%b", obs(), exp_v(2'b10, 1, 1, 2'd2));
        end
    endtask

    task automatic test_boundary();
        for (int i = 0; i < 4; i++) send(255);
        checks++;
        if (obs() !== exp_v(2'b10, 0, 0, 2'd2)) begin
            errors++;
            $display("FAIL bound_255_hold got=%b want=%b", obs(), exp_v(2'b10, 0, 0, 2'd2));
        end
        for (int i = 0; i < 4; i++) send(254);
        checks++;
        if (obs() !== exp_v(2'b00, 0, 1, 2'd2)) begin
            errors++;
            $display("FAIL bound_254_exit got=%b want=%b", obs(), exp_v(2'b00, 0, 1, 2'd2));
        end
        for (int i = 0; i < 4; i++) send(259);
        checks++;
        if (obs() !== exp_v(2'b00, 0, 0, 2'd2)) begin
            errors++;
            $display("FAIL bound_259_hold got=%b want=%b", obs(), exp_v(2'b00, 0, 0, 2'd2));
        end
        for (int i = 0; i < 4; i++) send(260);
        checks++;
        if (obs() !== exp_v(2'b10, 1, 1, 2'd3)) begin
            errors++;
            $display("FAIL bound_260_enter got=%b want=%b", obs(), exp_v(2'b10, 1, 1, 2'd3));
        end
        for (int i = 0; i < 4; i++) send(-1024);
        checks++;
        if (obs() !== exp_v(2'b01, 1, 1, 2'd3)) begin
            errors++;
            $display("FAIL neg_1024_frio got=%b want=%b", obs(), exp_v(2'b01, 1, 1, 2'd3));
        end
    endtask

    task automatic test_saturation_reset();
        for (int i = 0; i < 4; i++) send(300);
        checks++;
        if (obs() !== exp_v(2'b10, 1, 1, 2'd3)) begin
            errors++;
            $display("FAIL sat_hold got=%b want=%b", obs(), exp_v(2'b10, 1, 1, 2'd3));
        end
        send(170); send(170);
        @(negedge clk);
        bus.temp_valida  = 1'b1;
        bus.temp_entrada = 11'sd170;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.temp_valida = 1'b0;
        checks++;
        if (obs() !== exp_v(2'b00, 0, 0, 2'd0)) begin
            errors++;
            $display("FAIL midrun_reset got=%b want=%b", obs(), exp_v(2'b00, 0, 0, 2'd0));
        end
        for (int i = 0; i < 3; i++) send(170);
        checks++;
        if (obs() !== exp_v(2'b00, 0, 0, 2'd0)) begin
            errors++;
            $display("FAIL fresh_3 got=%b want=%b", obs(), exp_v(2'b00, 0, 0, 2'd0));
        end
        send(170);
        checks++;
        if (obs() !== exp_v(2'b01, 1, 1, 2'd1)) begin
            errors++;
            $display("FAIL fresh_4 got=%b want=%b", obs(), exp_v(2'b01, 1, 1, 2'd1));
        end
    endtask

    initial begin
        bus.temp_valida  = 1'b0;
        bus.temp_entrada = '0;
        test_reset();
        test_in_range();
        test_debounce();
        test_hysteresis();
        test_gapped();
        test_boundary();
        test_saturation_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/comparador_temp_histeresis.md
# comparador_temp_histeresis

Registered temperature classifier for the monitoring path. It sorts each valid sensor sample into FRIO, NORMAL or CALIENTE. Range entry and exit use hysteresis, and a new class is only accepted after N consecutive qualifying samples. It sits between the sensor scaling stage and the alarm/display logic, and supersedes the purely combinational out-of-range flag with debounced, stateful outputs and a saturating event counter.

## Interface
- `ANCHO`, 11: width of signed temperature sample (°C ×10).
- `TEMP_BAJO`, 180: 18.0 °C. A sample below this is cold.
- `TEMP_ALTO`, 259: 25.9 °C. A sample above this is hot.
- `HIST`, 5: hysteresis band (0.5 °C) applied on return to NORMAL.
- `N_MUESTRAS`, 4: consecutive valid samples required to change state; ≥1.
- `ANCHO_CNT`, 8: width of the alarm event counter.
- Legal parameters require `TEMP_BAJO + HIST <= TEMP_ALTO - HIST`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `temp_valida`, input, 1: `temp_entrada` holds a new sample this cycle.
- `temp_entrada`, input, signed `ANCHO`: sensor temperature.
- `estado`, output, 2: 2'b00 NORMAL, 2'b01 FRIO, 2'b10 CALIENTE (2'b11 never driven).
- `fuera_rango`, output, 1: high while `estado` ≠ NORMAL.
- `alarma`, output, 1: one-cycle pulse on any transition into FRIO or CALIENTE.
- `cambio`, output, 1: one-cycle pulse on any `estado` change.
- `num_alarmas`, output, `ANCHO_CNT`: count of `alarma` pulses, saturating at all-ones.

## Operation
- Comparisons are signed. Thresholds are sign-extended to `ANCHO`+1 bits before the ±HIST arithmetic, so there is no overflow.
- Target class `obj` is computed only on cycles with `temp_valida` = 1:
  - From NORMAL: `temp` < TEMP_BAJO gives FRIO. `temp` > TEMP_ALTO gives CALIENTE. Otherwise NORMAL.
  - From FRIO: `temp` > TEMP_ALTO gives CALIENTE. `temp` ≥ TEMP_BAJO+HIST gives NORMAL. Otherwise FRIO.
  - From CALIENTE: `temp` < TEMP_BAJO gives FRIO. `temp` ≤ TEMP_ALTO−HIST gives NORMAL. Otherwise CALIENTE.
- Persistence uses an internal `candidato` (2 bits) and `cuenta` (clog2(N_MUESTRAS+1) bits).
  - `obj` = `estado`: `cuenta` ← 0.
  - `obj` ≠ `estado` and `obj` = `candidato`: `cuenta` ← `cuenta`+1. When the incremented value equals N_MUESTRAS: `estado` ← `obj` and `cuenta` ← 0.
  - `obj` ≠ `estado` and `obj` ≠ `candidato`: `candidato` ← `obj` and `cuenta` ← 1. If N_MUESTRAS = 1, `estado` ← `obj` immediately and `cuenta` ← 0.
- Cycles with `temp_valida` = 0 hold all state. They do not break a run of qualifying samples.
- Direct FRIO↔CALIENTE transitions are allowed and pass through the same persistence rule.
- `alarma` and `num_alarmas` update on the same edge as `estado`.
  - A CALIENTE→FRIO transition counts as an alarm.
  - A return to NORMAL does not count.
- `num_alarmas` holds at 2^ANCHO_CNT−1 once saturated.

## Timing
- Reset values: `estado` = NORMAL, `candidato` = NORMAL, `cuenta` = 0, `fuera_rango` = 0, `alarma` = 0, `cambio` = 0, `num_alarmas` = 0.
- `rst` has priority over `temp_valida` on the same edge. Reset mid-run discards the partial count.
- All outputs are registered; there is no combinational path from input to output.
- Latency: the N_MUESTRAS-th qualifying valid sample is sampled at edge k. `estado`, `fuera_rango`, `alarma` and `cambio` reflect the change after edge k.
- `alarma` and `cambio` stay high for exactly one cycle, then deassert at the next edge.
- Back-to-back valid samples are accepted every cycle. Throughput is 1 sample/cycle.

## Test plan
- **Reset then in-range:** 10 valid samples of 220. Required: `estado` = 00, `fuera_rango` = 0, no pulses, `num_alarmas` = 0.
- **Debounce:** 3 valid samples of 170, then 220, then 4 × 170. Required:
  - No change during the first 3 samples or on the 220.
  - `estado` = 01 after the 4th consecutive 170.
  - `alarma` and `cambio` pulse for 1 cycle; `num_alarmas` = 1.
- **Hysteresis on exit:** from FRIO, 6 × 182. Required: stays FRIO. Then 4 × 185. Required: `estado` = 00, `cambio` pulses, `alarma` does not.
- **Gapped valid and candidate switch:**
  - From NORMAL, send 270, idle, 270, idle, 150, then 4 × 270, each separated by idle cycles.
  - Required: the 150 resets the candidate; CALIENTE is entered only after the 4 gapped 270s.
- **Negative and boundary values:** with ANCHO = 11, send −1024, and 259 vs 260 at the upper bound. Required:
  - −1024 classifies as FRIO, with no sign error.
  - 259 keeps NORMAL; 260 counts toward CALIENTE.
  - From CALIENTE, 254 returns to NORMAL and 255 does not.
- **Saturation and reset mid-run:** with ANCHO_CNT = 2, force 5 alarms. Required: `num_alarmas` = 3. Then assert `rst` after 2 of 4 qualifying samples. Required: all outputs return to reset values and the next transition needs 4 fresh samples.
